// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/forwarding controller.
package hazard_pkg;

  // Scoreboard rd field is sized for the widest register index we expect;
  // narrower RBITS values are zero-extended into it.
  localparam int RD_W = 8;

  // Pipeline register indices with a fixed meaning.
  localparam int STG_IF   = 0;
  localparam int STG_ID   = 1;
  localparam int SB_FIRST = 2;

  // Forward-select encoding: 0 means register file, otherwise the stage index.
  localparam int SEL_RF = 0;

  typedef struct packed {
    logic            v;
    logic            we;
    logic [RD_W-1:0] rd;
    logic            late;
  } sb_entry_t;

endpackage

// File: rtl/hazard_ctrl_fwd_select.sv
// Per-operand youngest-match search over the shadow scoreboard, with readiness check.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int RBITS      = 5,
  parameter int STAGES     = 5,
  parameter int ALU_STAGE  = 2,
  parameter int LOAD_STAGE = 3,
  parameter int SW         = $clog2(STAGES)
) (
  input  logic [RBITS-1:0]             i_rs,
  input  logic                         i_re,
  input  logic [XLEN-1:0]              i_rf,
  input  sb_entry_t [STAGES-1:2]       i_sb,
  input  logic [(STAGES-2)*XLEN-1:0]   i_stage_wd,
  output logic [SW-1:0]                o_sel,
  output logic [XLEN-1:0]              o_op,
  output logic                         o_hazard
);

  logic            w_hit;
  logic            w_ready;
  logic [SW-1:0]   w_stage;
  logic [XLEN-1:0] w_data;

  // Scan oldest to youngest so the last hit left standing is the youngest producer.
  always_comb begin
    w_hit   = 1'b0;
    w_ready = 1'b0;
    w_stage = '0;
    w_data  = '0;
    for (int s = STAGES-1; s >= 2; s--) begin
      if (i_sb[s].v && i_sb[s].we && (i_sb[s].rd != '0) && (i_sb[s].rd == RD_W'(i_rs))) begin
        w_hit   = 1'b1;
        w_stage = SW'(s);
        w_data  = i_stage_wd[(s-2)*XLEN +: XLEN];
        w_ready = (s >= ALU_STAGE) && (!i_sb[s].late || (s >= LOAD_STAGE));
      end
    end
  end

  // A youngest match that is not ready is a hazard; never fall back to an older match.
  always_comb begin
    o_sel    = SW'(SEL_RF);
    o_op     = i_rf;
    o_hazard = 1'b0;
    if (i_re && (i_rs != '0) && w_hit) begin
      if (w_ready) begin
        o_sel = w_stage;
        o_op  = w_data;
      end else begin
        o_hazard = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard, forwarding and stall/flush controller with a shadow destination scoreboard.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int RBITS      = 5,
  parameter int STAGES     = 5,
  parameter int BR_STAGE   = 2,
  parameter int ALU_STAGE  = 2,
  parameter int LOAD_STAGE = 3,
  parameter int SW         = $clog2(STAGES)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        id_valid_i,
  input  logic [RBITS-1:0]            id_rs1_i,
  input  logic [RBITS-1:0]            id_rs2_i,
  input  logic                        id_re1_i,
  input  logic                        id_re2_i,
  input  logic                        id_we_i,
  input  logic [RBITS-1:0]            id_rd_i,
  input  logic                        id_late_i,
  input  logic [XLEN-1:0]             rf_rd1_i,
  input  logic [XLEN-1:0]             rf_rd2_i,
  input  logic [(STAGES-2)*XLEN-1:0]  stage_wd_i,
  input  logic                        br_taken_i,
  input  logic                        mem_busy_i,
  output logic [STAGES-1:0]           stall_o,
  output logic [STAGES-1:0]           flush_o,
  output logic [XLEN-1:0]             op1_o,
  output logic [XLEN-1:0]             op2_o,
  output logic [SW-1:0]               fwd1_sel_o,
  output logic [SW-1:0]               fwd2_sel_o,
  output logic [31:0]                 hz_cnt_o
);

  sb_entry_t [STAGES-1:2] r_sb;
  logic [31:0]            r_hz_cnt;
  sb_entry_t              w_id_entry;
  logic                   w_hz1;
  logic                   w_hz2;
  logic [STAGES-1:0]      w_stall;
  logic [STAGES-1:0]      w_flush;

  fwd_select #(
    .XLEN(XLEN), .RBITS(RBITS), .STAGES(STAGES),
    .ALU_STAGE(ALU_STAGE), .LOAD_STAGE(LOAD_STAGE), .SW(SW)
  ) u_fwd1 (
    .i_rs(id_rs1_i), .i_re(id_re1_i), .i_rf(rf_rd1_i), .i_sb(r_sb),
    .i_stage_wd(stage_wd_i), .o_sel(fwd1_sel_o), .o_op(op1_o), .o_hazard(w_hz1)
  );

  fwd_select #(
    .XLEN(XLEN), .RBITS(RBITS), .STAGES(STAGES),
    .ALU_STAGE(ALU_STAGE), .LOAD_STAGE(LOAD_STAGE), .SW(SW)
  ) u_fwd2 (
    .i_rs(id_rs2_i), .i_re(id_re2_i), .i_rf(rf_rd2_i), .i_sb(r_sb),
    .i_stage_wd(stage_wd_i), .o_sel(fwd2_sel_o), .o_op(op2_o), .o_hazard(w_hz2)
  );

  // Pack the ID instruction fields into a scoreboard entry.
  always_comb begin
    w_id_entry      = '0;
    w_id_entry.v    = id_valid_i;
    w_id_entry.we   = id_we_i;
    w_id_entry.rd   = RD_W'(id_rd_i);
    w_id_entry.late = id_late_i;
  end

  // Control priority: memory wait, then branch flush, then data hazard.
  always_comb begin
    w_stall = '0;
    w_flush = '0;
    if (mem_busy_i) begin
      for (int k = 0; k <= LOAD_STAGE; k++) w_stall[k] = 1'b1;
      w_flush[LOAD_STAGE+1] = 1'b1;
    end else if (br_taken_i) begin
      for (int k = STG_ID; k <= BR_STAGE; k++) w_flush[k] = 1'b1;
    end else if (id_valid_i && (w_hz1 || w_hz2)) begin
      w_stall[STG_IF]   = 1'b1;
      w_stall[STG_ID]   = 1'b1;
      w_flush[SB_FIRST] = 1'b1;
    end
  end

  assign stall_o  = w_stall;
  assign flush_o  = w_flush;
  assign hz_cnt_o = r_hz_cnt;

  // Advance the shadow scoreboard alongside the pipeline registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sb <= '0;
    end else begin
      if (w_flush[SB_FIRST])       r_sb[SB_FIRST].v <= 1'b0;
      else if (!w_stall[SB_FIRST]) r_sb[SB_FIRST]   <= w_id_entry;
      for (int s = SB_FIRST+1; s < STAGES; s++) begin
        if (w_flush[s])       r_sb[s].v <= 1'b0;
        else if (!w_stall[s]) r_sb[s]   <= r_sb[s-1];
      end
    end
  end

  // Saturating count of cycles in which any pipeline register is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hz_cnt <= '0;
    end else if ((|w_stall) && (r_hz_cnt != '1)) begin
      r_hz_cnt <= r_hz_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized run vs. a reference model.
module tb_hazard_ctrl;

  localparam int XLEN   = 32;
  localparam int RBITS  = 5;
  localparam int STAGES = 5;
  localparam int BRS    = 2;
  localparam int ALUS   = 2;
  localparam int LOADS  = 3;
  localparam int SW     = $clog2(STAGES);

  logic                       clk = 1'b0;
  logic                       rst = 1'b0;
  logic                       id_valid_i, id_re1_i, id_re2_i, id_we_i, id_late_i;
  logic [RBITS-1:0]           id_rs1_i, id_rs2_i, id_rd_i;
  logic [XLEN-1:0]            rf_rd1_i, rf_rd2_i;
  logic [(STAGES-2)*XLEN-1:0] stage_wd_i;
  logic                       br_taken_i, mem_busy_i;
  logic [STAGES-1:0]          stall_o, flush_o;
  logic [XLEN-1:0]            op1_o, op2_o;
  logic [SW-1:0]              fwd1_sel_o, fwd2_sel_o;
  logic [31:0]                hz_cnt_o;

  int n_vec = 0;
  int n_err = 0;

  hazard_ctrl #(
    .XLEN(XLEN), .RBITS(RBITS), .STAGES(STAGES), .BR_STAGE(BRS),
    .ALU_STAGE(ALUS), .LOAD_STAGE(LOADS)
  ) dut (
    .clk(clk), .rst(rst), .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_re1_i(id_re1_i), .id_re2_i(id_re2_i), .id_we_i(id_we_i), .id_rd_i(id_rd_i),
    .id_late_i(id_late_i), .rf_rd1_i(rf_rd1_i), .rf_rd2_i(rf_rd2_i), .stage_wd_i(stage_wd_i),
    .br_taken_i(br_taken_i), .mem_busy_i(mem_busy_i), .stall_o(stall_o), .flush_o(flush_o),
    .op1_o(op1_o), .op2_o(op2_o), .fwd1_sel_o(fwd1_sel_o), .fwd2_sel_o(fwd2_sel_o),
    .hz_cnt_o(hz_cnt_o)
  );

  always #5 clk = ~clk;

  // Reference model: instructions in flight past ID, indexed by stage.
  typedef struct {
    bit v;
    bit we;
    int rd;
    bit late;
  } ment_t;

  ment_t       m [2:STAGES-1];
  logic [31:0] m_hz;

  function automatic void model_clear();
    for (int s = 2; s < STAGES; s++) m[s] = '{v: 0, we: 0, rd: 0, late: 0};
    m_hz = 32'd0;
  endfunction

  function automatic void model_fwd(input int rs, input bit re, input logic [XLEN-1:0] rf,
                                    output int sel, output logic [XLEN-1:0] op, output bit haz);
    sel = 0;
    op  = rf;
    haz = 0;
    if (!re || rs == 0) return;
    for (int s = 2; s < STAGES; s++) begin
      if (m[s].v && m[s].we && m[s].rd == rs) begin
        if (s >= ALUS && (!m[s].late || s >= LOADS)) begin
          sel = s;
          op  = stage_wd_i[(s-2)*XLEN +: XLEN];
        end else begin
          haz = 1;
        end
        return;
      end
    end
  endfunction

  function automatic void model_ctrl(output logic [STAGES-1:0] st, output logic [STAGES-1:0] fl);
    int sel;
    logic [XLEN-1:0] op;
    bit h1, h2;
    model_fwd(int'(id_rs1_i), id_re1_i, rf_rd1_i, sel, op, h1);
    model_fwd(int'(id_rs2_i), id_re2_i, rf_rd2_i, sel, op, h2);
    st = '0;
    fl = '0;
    if (mem_busy_i) begin
      st = (5'd1 << (LOADS+1)) - 5'd1;
      fl = 5'd1 << (LOADS+1);
    end else if (br_taken_i) begin
      fl = ((5'd1 << (BRS+1)) - 5'd1) & ~5'd1;
    end else if (id_valid_i && (h1 || h2)) begin
      st = 5'b00011;
      fl = 5'b00100;
    end
  endfunction

  function automatic void model_update();
    logic [STAGES-1:0] st, fl;
    ment_t nm [2:STAGES-1];
    model_ctrl(st, fl);
    for (int s = 2; s < STAGES; s++) begin
      nm[s] = m[s];
      if (fl[s])        nm[s].v = 0;
      else if (!st[s])  nm[s] = (s == 2) ?
                         '{v: id_valid_i, we: id_we_i, rd: int'(id_rd_i), late: id_late_i} : m[s-1];
    end
    for (int s = 2; s < STAGES; s++) m[s] = nm[s];
    if (st != '0 && m_hz != 32'hFFFF_FFFF) m_hz = m_hz + 32'd1;
  endfunction

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_idle();
    id_valid_i = 0; id_we_i = 0; id_rd_i = '0; id_late_i = 0;
    id_rs1_i = '0; id_rs2_i = '0; id_re1_i = 0; id_re2_i = 0;
    rf_rd1_i = $urandom; rf_rd2_i = $urandom;
    stage_wd_i = {$urandom, $urandom, $urandom};
    br_taken_i = 0; mem_busy_i = 0;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b1;
    model_clear();
    #3;
    rst = 1'b0;
    #1;
  endtask

  task automatic issue(input int rd, input bit late);
    set_idle();
    id_valid_i = 1; id_we_i = 1; id_rd_i = RBITS'(rd); id_late_i = late;
    #1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    set_idle();
    mem_busy_i = 1;
    #1; step(); step();
    issue(7, 1);
    set_idle();
    id_valid_i = 1; id_rs1_i = 5'd7; id_re1_i = 1;
    #1;
    n_vec++; if (stall_o !== 5'b00011) begin n_err++; $display("FAIL rst_pre_stall got=%b exp=%b", stall_o, 5'b00011); end
    n_vec++; if (hz_cnt_o !== 32'd2) begin n_err++; $display("FAIL rst_pre_cnt got=%0d exp=2", hz_cnt_o); end
    rst = 1'b1;
    model_clear();
    #1;
    n_vec++; if (stall_o !== '0) begin n_err++; $display("FAIL rst_stall got=%b exp=0", stall_o); end
    n_vec++; if (flush_o !== '0) begin n_err++; $display("FAIL rst_flush got=%b exp=0", flush_o); end
    n_vec++; if (hz_cnt_o !== 32'd0) begin n_err++; $display("FAIL rst_cnt got=%0d exp=0", hz_cnt_o); end
    n_vec++; if (op1_o !== rf_rd1_i || fwd1_sel_o !== '0) begin n_err++; $display("FAIL rst_op1 got=%h/%0d exp=%h/0", op1_o, fwd1_sel_o, rf_rd1_i); end
    #2;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_alu_fwd();
    do_reset();
    issue(5, 0);
    set_idle();
    id_valid_i = 1; id_rs1_i = 5'd5; id_re1_i = 1;
    stage_wd_i[31:0] = 32'h1234;
    #1;
    n_vec++; if (fwd1_sel_o !== 3'd2) begin n_err++; $display("FAIL alu_sel got=%0d exp=2", fwd1_sel_o); end
    n_vec++; if (op1_o !== 32'h1234) begin n_err++; $display("FAIL alu_op got=%h exp=1234", op1_o); end
    n_vec++; if (stall_o !== '0) begin n_err++; $display("FAIL alu_stall got=%b exp=0", stall_o); end
    step();
  endtask

  task automatic test_load_use();
    do_reset();
    issue(7, 1);
    set_idle();
    id_valid_i = 1; id_rs2_i = 5'd7; id_re2_i = 1;
    stage_wd_i[63:32] = 32'hCAFE;
    #1;
    n_vec++; if (stall_o !== 5'b00011) begin n_err++; $display("FAIL lu_stall got=%b exp=00011", stall_o); end
    n_vec++; if (flush_o !== 5'b00100) begin n_err++; $display("FAIL lu_flush got=%b exp=00100", flush_o); end
    step();
    #1;
    n_vec++; if (fwd2_sel_o !== 3'd3) begin n_err++; $display("FAIL lu_sel got=%0d exp=3", fwd2_sel_o); end
    n_vec++; if (op2_o !== 32'hCAFE) begin n_err++; $display("FAIL lu_op got=%h exp=cafe", op2_o); end
    n_vec++; if (stall_o !== '0) begin n_err++; $display("FAIL lu_release got=%b exp=0", stall_o); end
    n_vec++; if (hz_cnt_o !== 32'd1) begin n_err++; $display("FAIL lu_cnt got=%0d exp=1", hz_cnt_o); end
    step();
  endtask

  task automatic test_youngest();
    do_reset();
    issue(3, 0);
    issue(3, 0);
    set_idle();
    id_valid_i = 1; id_rs1_i = 5'd3; id_re1_i = 1;
    stage_wd_i[31:0] = 32'h11; stage_wd_i[63:32] = 32'h22;
    #1;
    n_vec++; if (op1_o !== 32'h11 || fwd1_sel_o !== 3'd2) begin n_err++; $display("FAIL young_op got=%h/%0d exp=11/2", op1_o, fwd1_sel_o); end
    // Youngest is a not-yet-ready load while an older ready ALU match exists.
    do_reset();
    issue(4, 0);
    issue(4, 1);
    set_idle();
    id_valid_i = 1; id_rs1_i = 5'd4; id_re1_i = 1;
    #1;
    n_vec++; if (stall_o !== 5'b00011) begin n_err++; $display("FAIL young_late got=%b exp=00011", stall_o); end
    do_reset();
    issue(0, 0);
    set_idle();
    id_valid_i = 1; id_rs1_i = 5'd0; id_re1_i = 1; id_rs2_i = 5'd0; id_re2_i = 1;
    #1;
    n_vec++; if (fwd1_sel_o !== '0 || op1_o !== rf_rd1_i) begin n_err++; $display("FAIL x0_op1 got=%h/%0d exp=%h/0", op1_o, fwd1_sel_o, rf_rd1_i); end
    n_vec++; if (fwd2_sel_o !== '0 || op2_o !== rf_rd2_i) begin n_err++; $display("FAIL x0_op2 got=%h/%0d exp=%h/0", op2_o, fwd2_sel_o, rf_rd2_i); end
    step();
  endtask

  task automatic test_busy_branch();
    do_reset();
    set_idle();
    mem_busy_i = 1; br_taken_i = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_vec++; if (stall_o !== 5'b01111) begin n_err++; $display("FAIL busy_stall c=%0d got=%b exp=01111", c, stall_o); end
      n_vec++; if (flush_o !== 5'b10000) begin n_err++; $display("FAIL busy_flush c=%0d got=%b exp=10000", c, flush_o); end
      step();
    end
    mem_busy_i = 0;
    #1;
    n_vec++; if (flush_o !== 5'b00110 || stall_o !== '0) begin n_err++; $display("FAIL busy_br got=%b/%b exp=00110/00000", flush_o, stall_o); end
    n_vec++; if (hz_cnt_o !== 32'd3) begin n_err++; $display("FAIL busy_cnt got=%0d exp=3", hz_cnt_o); end
    step();
  endtask

  task automatic test_br_hazard();
    do_reset();
    issue(7, 1);
    set_idle();
    id_valid_i = 1; id_rs2_i = 5'd7; id_re2_i = 1; br_taken_i = 1;
    #1;
    n_vec++; if (flush_o !== 5'b00110) begin n_err++; $display("FAIL brhz_flush got=%b exp=00110", flush_o); end
    n_vec++; if (stall_o !== '0) begin n_err++; $display("FAIL brhz_stall got=%b exp=0", stall_o); end
    step();
  endtask

  task automatic test_random();
    logic [STAGES-1:0] est, efl;
    int               es1, es2;
    logic [XLEN-1:0]  eo1, eo2;
    bit               h;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      id_valid_i = ($urandom_range(3) != 0);
      id_we_i    = $urandom_range(1);
      id_rd_i    = RBITS'($urandom_range(7));
      id_late_i  = $urandom_range(1);
      id_rs1_i   = RBITS'($urandom_range(7));
      id_rs2_i   = RBITS'($urandom_range(7));
      id_re1_i   = ($urandom_range(3) != 0);
      id_re2_i   = ($urandom_range(3) != 0);
      rf_rd1_i   = $urandom;
      rf_rd2_i   = $urandom;
      stage_wd_i = {$urandom, $urandom, $urandom};
      mem_busy_i = ($urandom_range(7) == 0);
      br_taken_i = ($urandom_range(7) == 0);
      #1;
      model_ctrl(est, efl);
      model_fwd(int'(id_rs1_i), id_re1_i, rf_rd1_i, es1, eo1, h);
      model_fwd(int'(id_rs2_i), id_re2_i, rf_rd2_i, es2, eo2, h);
      n_vec++; if (stall_o !== est) begin n_err++; $display("FAIL rnd_stall c=%0d got=%b exp=%b", c, stall_o, est); end
      n_vec++; if (flush_o !== efl) begin n_err++; $display("FAIL rnd_flush c=%0d got=%b exp=%b", c, flush_o, efl); end
      n_vec++; if (fwd1_sel_o !== SW'(es1) || op1_o !== eo1) begin n_err++; $display("FAIL rnd_op1 c=%0d got=%0d/%h exp=%0d/%h", c, fwd1_sel_o, op1_o, es1, eo1); end
      n_vec++; if (fwd2_sel_o !== SW'(es2) || op2_o !== eo2) begin n_err++; $display("FAIL rnd_op2 c=%0d got=%0d/%h exp=%0d/%h", c, fwd2_sel_o, op2_o, es2, eo2); end
      n_vec++; if (hz_cnt_o !== m_hz) begin n_err++; $display("FAIL rnd_cnt c=%0d got=%0d exp=%0d", c, hz_cnt_o, m_hz); end
      step();
    end
  endtask

  initial begin
    model_clear();
    set_idle();
    rst = 1'b1;
    #12;
    rst = 1'b0;
    #1;
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_youngest();
    test_busy_branch();
    test_br_hazard();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised hazard, forwarding and stall/flush controller for the in-order RISC-V pipeline. The controller keeps its own shadow scoreboard of destination registers for every stage past ID. From that scoreboard it produces:
- per-register stall and flush vectors;
- forwarded operand values for ID.

It handles load-use stalls, variable-latency data memory (busy wait), and branch flush at a configurable resolution stage. It counts hazard cycles. It sits beside the pipeline registers in the CPU top and replaces the fixed 5-stage hazard logic.

## Interface
Parameters:
- XLEN, 32, datapath width
- RBITS, 5, register index width
- STAGES, 5, pipeline stage count (stage 0=IF, 1=ID, 2..STAGES-1 downstream); minimum 4
- BR_STAGE, 2, stage in which br_taken_i is valid; range 2..STAGES-2
- ALU_STAGE, 2, first stage whose stage_wd_i holds a non-late result
- LOAD_STAGE, 3, first stage whose stage_wd_i holds a late (load) result; LOAD_STAGE ≥ ALU_STAGE and ≤ STAGES-2

Ports (SW = $clog2(STAGES)):
- clk in 1: the single clock
- rst in 1: asynchronous, active-high reset
- id_valid_i in 1: ID holds a real instruction
- id_rs1_i, id_rs2_i in RBITS: ID source registers
- id_re1_i, id_re2_i in 1: source register is actually read
- id_we_i in 1: ID instruction writes the register file
- id_rd_i in RBITS: ID destination register
- id_late_i in 1: result is available only from LOAD_STAGE
- rf_rd1_i, rf_rd2_i in XLEN: register-file read data
- stage_wd_i in (STAGES-2)*XLEN: write data of stage s, at slice [(s-2)*XLEN +: XLEN]
- br_taken_i in 1: taken branch/jump in BR_STAGE
- mem_busy_i in 1: data memory is not done this cycle
- stall_o out STAGES: bit k holds pipeline register k (0=PC, k=register feeding stage k)
- flush_o out STAGES: bit k loads a bubble into register k
- op1_o, op2_o out XLEN: forwarded operands for ID
- fwd1_sel_o, fwd2_sel_o out SW: 0 = register file, s = stage s
- hz_cnt_o out 32: saturating count of cycles with any stall_o bit set

## Operation
Shadow scoreboard:
- For s = 2..STAGES-1, each entry holds {v, we, rd, late}.
- The producer condition is v & we & rd≠0.

Advance rules per clock:
- Entry s takes entry s-1; entry 2 takes the ID fields.
- Where stall_o[s]=1, the entry holds its value.
- Where flush_o[s]=1, the entry becomes a bubble (v=0).

Forwarding, evaluated separately for each operand:
- Candidate: the youngest stage s (lowest index) whose entry is a producer and whose rd equals rs.
- If rs=0, re=0, or there is no candidate: sel=0 and op = rf value.
- If a candidate exists and its data is ready (s ≥ ALU_STAGE, or s ≥ LOAD_STAGE when late): sel=s and op = stage_wd_i slice s.
- If a candidate exists but is not ready, this is a data hazard. An older ready match must never be used instead.

Priority of control conditions, evaluated each cycle:
1. mem_busy_i:
   - stall_o[0..LOAD_STAGE]=1 and flush_o[LOAD_STAGE+1]=1.
   - The branch and data-hazard actions are suppressed.
   - The upstream logic keeps br_taken_i asserted because BR_STAGE is held.
2. br_taken_i:
   - flush_o[1..BR_STAGE]=1.
   - PC is not stalled, so it loads the target.
   - Overrides a simultaneous data hazard.
3. Data hazard with id_valid_i:
   - stall_o[0..1]=1 and flush_o[2]=1.
4. Otherwise: all bits are 0.

hz_cnt_o:
- Increments on every clock with |stall_o.
- Saturates at 32'hFFFF_FFFF.

Reset:
- All scoreboard entries have v=0 and hz_cnt_o=0.
- Consequently stall_o=0, flush_o=0, sel=0 and op = rf values.

## Timing
- stall_o, flush_o, op and sel are combinational from the inputs and the scoreboard, with no added latency.
- The scoreboard updates on the rising clk edge.
- Load-use distance of 1 (default parameters): exactly 1 stall cycle, then sel=3.
- A late producer d stages behind ID: max(0, LOAD_STAGE-1-d) stall cycles.
- During an N-cycle mem_busy_i:
  - stall/flush stay constant for N cycles.
  - The stages behind LOAD_STAGE drain and their bubbles propagate.
  - A pending branch flush takes effect in cycle N+1.
- Reset asserted mid-stall clears the scoreboard immediately (asynchronous). The outputs are 0 in the same cycle.

## Structure
- Shared package hazard_pkg holds:
  - the scoreboard entry struct {v, we, rd, late};
  - stage index constants (IF=0, ID=1);
  - the sel encoding.
- One sub-module, fwd_select, is instantiated twice (one per operand). It performs the youngest-match search and the ready check, and returns sel, op and hazard.

## Test plan
- Reset: assert rst mid-operation -> stall_o=0, flush_o=0, hz_cnt_o=0, op1_o=rf_rd1_i.
- ALU producer x5 (not late) in EX, ID reads rs1=x5 with EX data 0x1234 -> fwd1_sel_o=2, op1_o=0x1234, no stall.
- Load x7 in EX, ID reads rs2=x7:
  - Cycle 1: stall_o=5'b00011, flush_o=5'b00100.
  - Cycle 2: fwd2_sel_o=3 and op2_o = MEM data 0xCAFE.
  - Result: hz_cnt_o=1.
- x3 produced in both EX (0x11) and MEM (0x22) -> op1_o=0x11. Producer with rd=x0 and ID reads x0 -> sel=0 and op = rf value.
- mem_busy_i for 3 cycles while br_taken_i is held:
  - Cycles 1-3: stall_o=5'b01111, flush_o=5'b10000 each cycle.
  - Cycle 4: flush_o=5'b00110.
  - Result: hz_cnt_o=3.
- Simultaneous load-use hazard and br_taken_i -> flush_o=5'b00110 and stall_o=0.
